// File: rtl/uart_rx_if.sv
// UART receiver output bundle.
// master = receiver side, slave = consumer/line driver.
interface uart_rx_if;
  logic       din;
  logic [7:0] data_out;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  modport master (
    input  din,
    output data_out,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    output din,
    input  data_out,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-FF sync, mid-bit sampling, parity/stop checks.
// Option: UART_RX_MAJORITY_EN = 3-sample majority per bit.
`ifndef UART_FULL_ETU
`define UART_FULL_ETU 15
`endif

module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter bit PARITY_EN   = 1'b1,
  parameter bit PARITY_EVEN = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.master bus
);

  localparam logic [9:0] PM1 = 10'(`UART_FULL_ETU);
  localparam logic [9:0] H   = 10'(`UART_FULL_ETU >> 1);
  localparam logic [2:0] LASTB = 3'(DATA_BITS - 1);
  localparam logic [1:0] LASTS = 2'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               r_state, w_state;
  logic [9:0]           r_etu, w_etu;
  logic [2:0]           r_bit, w_bitc;
  logic [1:0]           r_stop, w_stop;
  logic [DATA_BITS-1:0] r_shreg, w_shreg;
  logic                 r_pacc, w_pacc;
  logic                 r_facc, w_facc;
  logic                 r_sync1, r_sync2;
  logic                 r_armed;
  logic [7:0]           r_data;
  logic                 r_valid, r_perr, r_ferr;
  logic                 w_rx, w_bit, w_start_pt;
  logic                 w_bit_pt, w_done, w_pexp;

  assign w_rx     = r_sync2;
  assign w_bit_pt = (r_etu == PM1);
  assign w_pexp   = PARITY_EVEN ? ^r_shreg
                                : ~^r_shreg;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_hist;

  // Two previous line samples for the vote
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hist <= 2'b11;
    else        r_hist <= {r_hist[0], w_rx};
  end

  assign w_bit = (r_hist[1] & r_hist[0])
               | (r_hist[1] & w_rx)
               | (r_hist[0] & w_rx);
  assign w_start_pt = (r_etu == H + 10'd1);
`else
  assign w_bit      = w_rx;
  assign w_start_pt = (r_etu == H);
`endif

  // Line synchroniser, idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.din;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counters and accumulators
  always_comb begin
    w_state = r_state;
    w_etu   = w_bit_pt ? 10'd0 : r_etu + 10'd1;
    w_bitc  = r_bit;
    w_stop  = r_stop;
    w_shreg = r_shreg;
    w_pacc  = r_pacc;
    w_facc  = r_facc;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_etu  = 10'd0;
        w_pacc = 1'b0;
        w_facc = 1'b0;
        if (r_armed && !w_rx)
          w_state = S_START;
      end
      S_START: begin
        if (w_start_pt) begin
          w_etu  = 10'd0;
          w_bitc = 3'd0;
          w_state = w_bit ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_pt) begin
          w_shreg = {w_bit,
                     r_shreg[DATA_BITS-1:1]};
          if (r_bit == LASTB) begin
            w_stop  = 2'd0;
            w_state = PARITY_EN ? S_PARITY
                                : S_STOP;
          end else begin
            w_bitc = r_bit + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_pt) begin
          w_pacc  = (w_bit != w_pexp);
          w_stop  = 2'd0;
          w_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_pt) begin
          if (!w_bit) w_facc = 1'b1;
          if (r_stop == LASTS) begin
            w_done  = 1'b1;
            w_state = S_IDLE;
          end else begin
            w_stop = r_stop + 2'd1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_etu   = 10'd0;
      end
    endcase
  end

  // FSM state and frame working registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_etu   <= 10'd0;
      r_bit   <= 3'd0;
      r_stop  <= 2'd0;
      r_shreg <= '0;
      r_pacc  <= 1'b0;
      r_facc  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_etu   <= w_etu;
      r_bit   <= w_bitc;
      r_stop  <= w_stop;
      r_shreg <= w_shreg;
      r_pacc  <= w_pacc;
      r_facc  <= w_facc;
    end
  end

  // Re-arm only after the line is seen high while idle,
  // so a held-low break yields a single frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_armed <= 1'b0;
    else if (r_state == S_IDLE && w_state == S_START)
      r_armed <= 1'b0;
    else if (r_state == S_IDLE && w_rx)
      r_armed <= 1'b1;
  end

  // Output byte and flags, updated once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_data <= 8'(r_shreg);
        r_perr <= w_pacc;
        r_ferr <= w_facc;
      end
    end
  end

  assign bus.data_out   = r_data;
  assign bus.valid      = r_valid;
  assign bus.parity_err = r_perr;
  assign bus.frame_err  = r_ferr;
  assign bus.busy       = (r_state != S_IDLE);

endmodule
